// File: rtl/mvm_pkg.sv
// Purpose  : shared types and sizing helpers for the streaming matrix-vector core.
// Latency  : n/a (declarations only).
// Backpress: n/a.
package mvm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_M,
    S_LOAD_V,
    S_COMPUTE,
    S_OUTPUT
  } state_e;

  // Accumulator width that can hold a K-term sum of BxB signed products.
  function automatic int acc_width(input int b, input int k);
    return 2 * b + $clog2(k);
  endfunction

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int groups(input int k, input int p);
    return k / p;
  endfunction

  // Each bank holds K/P rows of K words.
  function automatic int bank_aw(input int k, input int p);
    return idx_w(k * k / p);
  endfunction

  // Sizing for the default build (K=8, P=8, B=20).
  localparam int DEF_K   = 8;
  localparam int DEF_P   = 8;
  localparam int DEF_B   = 20;
  localparam int GROUPS  = DEF_K / DEF_P;
  localparam int BANK_AW = bank_aw(DEF_K, DEF_P);
  localparam int VEC_AW  = idx_w(DEF_K);

endpackage

// File: rtl/mvm_mac_lane.sv
// Purpose  : one MAC lane; registers a*x, then accumulates sign-extended products.
// Latency  : product visible 1 cycle after prod_en, accumulated 1 cycle after acc_en.
// Backpress: none; the enables are driven by the compute sequencer.
// Ports    : a/x operands, prod_en, acc_en, acc_clr (load instead of add), acc result.
module mvm_mac_lane #(
  parameter int B     = 20,
  parameter int ACC_W = 43
) (
  input  logic             clk,
  input  logic [B-1:0]     a,
  input  logic [B-1:0]     x,
  input  logic             prod_en,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic [ACC_W-1:0] acc
);
  logic [2*B-1:0]   prod;
  logic [ACC_W-1:0] prod_ext;

  always_ff @(posedge clk) begin
    if (prod_en) prod <= $signed(a) * $signed(x);
  end

  assign prod_ext = {{(ACC_W - 2 * B){prod[2*B-1]}}, prod};

  // acc_clr marks the first product of a row group: load rather than add.
  always_ff @(posedge clk) begin
    if (acc_en) acc <= acc_clr ? prod_ext : acc + prod_ext;
  end

endmodule

// File: rtl/mvm_stream_core.sv
// Purpose  : streaming signed y = A*x with P lanes over resident A (P banks) and x.
// Latency  : (K/P)*(K+3) compute cycles after start, then y[0..K-1] streamed in order.
// Backpress: in_ready only in load states; out_data held while out_ready is low.
// Ports    : clk/reset (sync, active-low); cmd_load_m/cmd_load_v/start commands;
//            in_valid/in_ready/in_data operand stream; out_valid/out_ready/out_data
//            result stream; busy (not idle); done (pulse after last y transfers).
module mvm_stream_core
  import mvm_pkg::*;
#(
  parameter int K     = 8,
  parameter int P     = 8,
  parameter int B     = 20,
  parameter int ACC_W = acc_width(B, K)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_load_m,
  input  logic             cmd_load_v,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [B-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             busy,
  output logic             done
);
  localparam int GRP = groups(K, P);
  localparam int AW  = bank_aw(K, P);
  localparam int VW  = idx_w(K);
  localparam int BW  = idx_w(P);
  localparam int GW  = idx_w(GRP);
  localparam int TW  = $clog2(K + 4);

  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [TW-1:0] T_TWO  = TW'(2);
  localparam logic [TW-1:0] T_K    = TW'(K);
  localparam logic [TW-1:0] T_K1   = TW'(K + 1);
  localparam logic [TW-1:0] T_LAST = TW'(K + 2);

  if (K % P != 0) begin : g_bad_kp
    $error("mvm_stream_core: K must be a multiple of P");
  end

  state_e         state_q, state_d;
  logic [VW-1:0]  col_q;   // column on matrix load, x index, y index on output
  logic [BW-1:0]  bsel_q;  // bank of the row being loaded (row % P)
  logic [GW-1:0]  grp_q;   // row group (row / P) for both load and compute
  logic [TW-1:0]  tcnt_q;  // cycle within a compute group, 0..K+2
  logic           done_q;

  logic col_last, bsel_last, grp_last, t_last, in_fire, out_fire;

  assign col_last  = (col_q == VW'(K - 1));
  assign bsel_last = (bsel_q == BW'(P - 1));
  assign grp_last  = (grp_q == GW'(GRP - 1));
  assign t_last    = (tcnt_q == T_LAST);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start)           state_d = S_COMPUTE;
        else if (cmd_load_m) state_d = S_LOAD_M;
        else if (cmd_load_v) state_d = S_LOAD_V;
      end
      S_LOAD_M: begin
        in_ready = 1'b1;
        if (in_valid && col_last && bsel_last && grp_last) state_d = S_IDLE;
      end
      S_LOAD_V: begin
        in_ready = 1'b1;
        if (in_valid && col_last) state_d = S_IDLE;
      end
      S_COMPUTE: begin
        if (t_last && grp_last) state_d = S_OUTPUT;
      end
      S_OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready && col_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      bsel_q  <= '0;
      grp_q   <= '0;
      tcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= out_fire && col_last;
      case (state_q)
        S_IDLE: begin
          col_q  <= '0;
          bsel_q <= '0;
          grp_q  <= '0;
          tcnt_q <= '0;
        end
        S_LOAD_M: if (in_fire) begin
          col_q <= col_last ? '0 : col_q + 1'b1;
          if (col_last) begin
            bsel_q <= bsel_last ? '0 : bsel_q + 1'b1;
            if (bsel_last) grp_q <= grp_last ? '0 : grp_q + 1'b1;
          end
        end
        S_LOAD_V: if (in_fire) col_q <= col_last ? '0 : col_q + 1'b1;
        S_COMPUTE: begin
          tcnt_q <= t_last ? '0 : tcnt_q + 1'b1;
          if (t_last) grp_q <= grp_last ? '0 : grp_q + 1'b1;
        end
        S_OUTPUT: if (out_fire) col_q <= col_last ? '0 : col_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;

  // Storage: bank r%P holds row r at (r/P)*K; nothing here is cleared by reset.
  logic [B-1:0]     bank_mem [P][GRP*K];
  logic [B-1:0]     x_mem    [K];
  logic [ACC_W-1:0] y_mem    [K];
  logic [B-1:0]     rd_a     [P];
  logic [B-1:0]     rd_x;
  logic [ACC_W-1:0] acc      [P];
  logic [VW-1:0]    rd_col;
  logic [AW-1:0]    wr_addr, rd_addr;
  logic             in_comp;

  assign in_comp = (state_q == S_COMPUTE);
  assign rd_col  = (tcnt_q < T_K) ? tcnt_q[VW-1:0] : '0;
  assign wr_addr = AW'(int'(grp_q) * K + int'(col_q));
  assign rd_addr = AW'(int'(grp_q) * K + int'(rd_col));

  always_ff @(posedge clk) begin
    if (reset && state_q == S_LOAD_M && in_valid) bank_mem[bsel_q][wr_addr] <= in_data;
    if (reset && state_q == S_LOAD_V && in_valid) x_mem[col_q] <= in_data;
    rd_x <= x_mem[rd_col];
    for (int i = 0; i < P; i++) rd_a[i] <= bank_mem[i][rd_addr];
    // Last product of the group lands at tcnt K+1, so acc is final at K+2.
    if (reset && in_comp && t_last)
      for (int i = 0; i < P; i++) y_mem[VW'(int'(grp_q) * P + i)] <= acc[i];
  end

  // Read issued at tcnt j, product registered at j+1, accumulated at j+2.
  logic prod_en, acc_en, acc_clr;
  assign prod_en = in_comp && (tcnt_q >= T_ONE) && (tcnt_q <= T_K);
  assign acc_en  = in_comp && (tcnt_q >= T_TWO) && (tcnt_q <= T_K1);
  assign acc_clr = (tcnt_q == T_TWO);

  for (genvar i = 0; i < P; i++) begin : g_lane
    mvm_mac_lane #(.B(B), .ACC_W(ACC_W)) u_lane (
      .clk     (clk),
      .a       (rd_a[i]),
      .x       (rd_x),
      .prod_en (prod_en),
      .acc_en  (acc_en),
      .acc_clr (acc_clr),
      .acc     (acc[i])
    );
  end

  assign out_data = y_mem[col_q];

endmodule

// File: tb/tb_mvm_stream_core.sv
`timescale 1ns/1ps
module tb_mvm_stream_core;
  localparam int SK = 4, SP = 2, SB = 8, SAW = 18;
  localparam int LK = 8, LP = 8, LB = 20, LAW = 43;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic cmd_load_m, cmd_load_v, start, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [SB-1:0]  in_data;
  logic [SAW-1:0] out_data;

  logic b_cmd_load_m, b_cmd_load_v, b_start, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy, b_done;
  logic [LB-1:0]  b_in_data;
  logic [LAW-1:0] b_out_data;

  mvm_stream_core #(.K(SK), .P(SP), .B(SB), .ACC_W(SAW)) u_small (
    .clk(clk), .reset(reset), .cmd_load_m(cmd_load_m), .cmd_load_v(cmd_load_v), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy), .done(done)
  );

  mvm_stream_core #(.K(LK), .P(LP), .B(LB), .ACC_W(LAW)) u_large (
    .clk(clk), .reset(reset), .cmd_load_m(b_cmd_load_m), .cmd_load_v(b_cmd_load_v), .start(b_start),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy), .done(b_done)
  );

  typedef struct packed {
    logic                  load_a;
    logic                  gaps;
    logic [3:0]            rdy;   // out_ready pattern, bit (cycle % 4)
    logic [15:0][SB-1:0]   a;     // row-major, a[r*4+c]
    logic [3:0][SB-1:0]    x;
    logic [3:0][SAW-1:0]   y;     // expected result
  } vec_t;

  vec_t tbl [7];
  int nvec = 0;
  int nerr = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0][SB-1:0] v4(input int e0, input int e1, input int e2, input int e3);
    logic [3:0][SB-1:0] r;
    r[0] = SB'(e0); r[1] = SB'(e1); r[2] = SB'(e2); r[3] = SB'(e3);
    return r;
  endfunction

  function automatic logic [3:0][SAW-1:0] y4(input int e0, input int e1, input int e2, input int e3);
    logic [3:0][SAW-1:0] r;
    r[0] = SAW'(e0); r[1] = SAW'(e1); r[2] = SAW'(e2); r[3] = SAW'(e3);
    return r;
  endfunction

  // kind 0: identity, 1: all -128, 2: A[r][c] = r*4+c
  function automatic logic [15:0][SB-1:0] mat(input int kind);
    logic [15:0][SB-1:0] m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r*4+c] = (kind == 0) ? SB'(r == c ? 1 : 0) : (kind == 1) ? SB'(-128) : SB'(r * 4 + c);
    return m;
  endfunction

  task automatic load_small(input bit is_mat, input logic [15:0][SB-1:0] words, input int nw,
                            input bit gaps, input string tag);
    bit rdy_ok = 1'b1;
    if (is_mat) cmd_load_m = 1'b1; else cmd_load_v = 1'b1;
    tick();
    cmd_load_m = 1'b0;
    cmd_load_v = 1'b0;
    for (int n = 0; n < nw; n++) begin
      if (gaps) begin
        in_valid = 1'b0;
        in_data  = 8'h55;   // junk that must not be written
        tick();
        if (!in_ready) rdy_ok = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = words[n];
      if (!in_ready) rdy_ok = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    check({tag, "_load_in_ready"}, rdy_ok, 1);
    check({tag, "_idle_in_ready"}, in_ready, 0);
  endtask

  task automatic run_small(input vec_t v, input string tag);
    int cyc = 0, p = 0, k = 0;
    bit bad = 1'b0, stalled = 1'b0;
    logic [SAW-1:0] held = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (busy && !out_valid && cyc < 100) begin
      if (in_ready) bad = 1'b1;
      cyc++;
      tick();
    end
    check({tag, "_compute_cycles"}, cyc, 14);
    while (k < 4 && p < 64) begin
      out_ready = v.rdy[p % 4];
      if (in_ready || !out_valid || done) bad = 1'b1;
      if (stalled) check({tag, "_hold"}, out_data, held);
      if (out_ready) begin
        check($sformatf("%s_y%0d", tag, k), $signed(out_data), $signed(v.y[k]));
        k++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = out_data;
      end
      p++;
      tick();
    end
    out_ready = 1'b0;
    check({tag, "_handshake"}, bad, 0);
    check({tag, "_done"}, done, 1);
    check({tag, "_valid_after"}, out_valid, 0);
    check({tag, "_busy_after"}, busy, 0);
    tick();
    check({tag, "_done_pulse"}, done, 0);
  endtask

  task automatic big_iter(input int it);
    logic [LB-1:0] a [64];
    logic [LB-1:0] x [8];
    longint y [8];
    int cyc = 0;
    bit bad = 1'b0;
    for (int n = 0; n < 64; n++) a[n] = (it == 0) ? 20'h80000 : LB'($urandom);
    for (int j = 0; j < 8; j++)  x[j] = (it == 0) ? 20'h80000 : LB'($urandom);
    for (int r = 0; r < 8; r++) begin
      y[r] = 0;
      for (int c = 0; c < 8; c++) y[r] += longint'($signed(a[r*8+c])) * longint'($signed(x[c]));
    end
    b_cmd_load_m = 1'b1; tick(); b_cmd_load_m = 1'b0;
    b_in_valid = 1'b1;
    for (int n = 0; n < 64; n++) begin
      b_in_data = a[n];
      if (!b_in_ready) bad = 1'b1;
      tick();
    end
    b_in_valid = 1'b0;
    b_cmd_load_v = 1'b1; tick(); b_cmd_load_v = 1'b0;
    b_in_valid = 1'b1;
    for (int j = 0; j < 8; j++) begin
      b_in_data = x[j];
      if (!b_in_ready) bad = 1'b1;
      tick();
    end
    b_in_valid = 1'b0;
    // start and cmd_load_m together: start must win
    b_start = 1'b1; b_cmd_load_m = 1'b1;
    tick();
    b_start = 1'b0; b_cmd_load_m = 1'b0;
    check($sformatf("big%0d_priority_in_ready", it), b_in_ready, 0);
    while (b_busy && !b_out_valid && cyc < 100) begin
      cyc++;
      tick();
    end
    check($sformatf("big%0d_compute_cycles", it), cyc, 11);
    b_out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if (!b_out_valid) bad = 1'b1;
      check($sformatf("big%0d_y%0d", it, j), $signed(b_out_data), y[j]);
      tick();
    end
    b_out_ready = 1'b0;
    check($sformatf("big%0d_done", it), b_done, 1);
    check($sformatf("big%0d_handshake", it), bad, 0);
  endtask

  initial begin
    bit flag;
    reset = 1'b0;
    {cmd_load_m, cmd_load_v, start, in_valid, out_ready} = '0;
    {b_cmd_load_m, b_cmd_load_v, b_start, b_in_valid, b_out_ready} = '0;
    in_data = '0;
    b_in_data = '0;

    tbl[0] = '{load_a: 1'b1, gaps: 1'b0, rdy: 4'b1111, a: mat(0), x: v4(1, 2, 3, 4),     y: y4(1, 2, 3, 4)};
    tbl[1] = '{load_a: 1'b1, gaps: 1'b0, rdy: 4'b1111, a: mat(1), x: v4(-128, -128, -128, -128),
               y: y4(65536, 65536, 65536, 65536)};
    tbl[2] = '{load_a: 1'b0, gaps: 1'b0, rdy: 4'b1111, a: '0,     x: v4(127, 127, 127, 127),
               y: y4(-65024, -65024, -65024, -65024)};
    tbl[3] = '{load_a: 1'b1, gaps: 1'b0, rdy: 4'b1001, a: mat(2), x: v4(1, -1, 2, -2),   y: y4(-3, -3, -3, -3)};
    tbl[4] = '{load_a: 1'b0, gaps: 1'b0, rdy: 4'b1001, a: '0,     x: v4(1, 0, 0, 0),     y: y4(0, 4, 8, 12)};
    tbl[5] = '{load_a: 1'b1, gaps: 1'b1, rdy: 4'b1111, a: mat(2), x: v4(1, -1, 2, -2),   y: y4(-3, -3, -3, -3)};
    tbl[6] = '{load_a: 1'b0, gaps: 1'b1, rdy: 4'b0101, a: '0,     x: v4(3, -2, 0, 1),    y: y4(1, 9, 17, 25)};

    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_big_busy", b_busy, 0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].load_a) load_small(1'b1, tbl[i].a, 16, tbl[i].gaps, $sformatf("v%0d_m", i));
      load_small(1'b0, 128'(tbl[i].x), 4, tbl[i].gaps, $sformatf("v%0d_x", i));
      run_small(tbl[i], $sformatf("v%0d", i));
    end

    // Reset partway through COMPUTE, with a command arriving that must be ignored.
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    cmd_load_v = 1'b1; tick(); cmd_load_v = 1'b0;
    check("cmd_ignored_in_ready", in_ready, 0);
    check("cmd_ignored_busy", busy, 1);
    reset = 1'b0; tick(); reset = 1'b1;
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_done", done, 0);
    flag = 1'b0;
    repeat (20) begin
      tick();
      if (done || busy) flag = 1'b1;
    end
    check("midrst_quiet", flag, 0);
    run_small(tbl[6], "rerun");

    for (int it = 0; it < 100; it++) big_iter(it);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
